// File: rtl/dmem_responder.sv
// dmem_responder: registered, fixed-latency data-memory target with
// valid/ready request and response handshakes.
// Optional feature macro: DMEM_BYTE_EN_EN (adds req_be byte strobes for stores).
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LAT      = 2,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [63:0]      req_addr,
  input  logic [63:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
`ifdef DMEM_BYTE_EN_EN
  input  logic [7:0]       req_be,
`endif
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [63:0]      resp_rdata,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_resp_valid;
  logic [63:0]      r_rdata;
  logic [TAG_W-1:0] r_tag;
  logic             r_err;
  logic [63:0]      r_mem [DEPTH_WORDS];

  logic [AW-1:0]    w_idx;
  logic             w_err;
  logic             w_acc;
  logic [7:0]       w_be;
  logic [63:0]      w_bmask;
  logic [63:0]      w_old;
  logic [63:0]      w_merged;

  assign w_idx = req_addr[3 +: AW];
  // Misaligned, or any word-address bit above the array index set.
  assign w_err = (req_addr[2:0] != 3'b000) || (req_addr[63:3+AW] != '0);
  assign req_ready = (r_state == IDLE) && !rst;
  assign w_acc = req_valid && req_ready;
  assign w_old = r_mem[w_idx];

`ifdef DMEM_BYTE_EN_EN
  assign w_be = req_be;
`else
  assign w_be = 8'hFF;
`endif

  // Expand byte strobes into a bit mask and merge store data with the old word.
  always_comb begin
    w_bmask = '0;
    for (int b = 0; b < 8; b++) w_bmask[8*b +: 8] = {8{w_be[b]}};
    w_merged = (w_old & ~w_bmask) | (req_wdata & w_bmask);
  end

  // Array write at acceptance; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_acc && req_we && !w_err) r_mem[w_idx] <= w_merged;
  end

  // Control FSM: capture at acceptance, count latency, hold response until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_tag        <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_rdata <= w_err ? 64'd0 : w_old;
          r_tag   <= req_tag;
          r_err   <= w_err;
          if (RD_LAT == 1) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
          end else begin
            r_state <= WAIT;
            r_cnt   <= CW'(RD_LAT - 1);
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
          end
        end
        RESP: if (resp_ready) begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_tag   = r_tag;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: reference model of the word array plus an
// expected-response queue, checked every negedge, with directed literal checks.
module tb_dmem_responder;
  localparam int DEPTH  = 256;
  localparam int RD_LAT = 2;
  localparam int TAG_W  = 5;

  logic             clk = 0;
  logic             rst = 1;
  logic             req_valid = 0, req_we = 0, resp_ready = 1;
  logic [63:0]      req_addr = 0, req_wdata = 0;
  logic [TAG_W-1:0] req_tag = 0;
  logic [7:0]       req_be = 8'hFF;
  logic             req_ready, resp_valid, resp_err;
  logic [63:0]      resp_rdata;
  logic [TAG_W-1:0] resp_tag;

  int checks = 0, errors = 0, cyc = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .RD_LAT(RD_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
`ifdef DMEM_BYTE_EN_EN
    .req_be(req_be),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_tag(resp_tag), .resp_err(resp_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model
  typedef struct {
    logic [63:0]      rdata;
    bit               known;
    logic [TAG_W-1:0] tag;
    bit               err;
    int               acc;
    bit               seen;
  } exp_t;

  logic [63:0] mem   [DEPTH];
  bit          known [DEPTH];
  exp_t        q[$];

  initial for (int i = 0; i < DEPTH; i++) known[i] = 0;

  // Every negedge: compare handshake and response outputs against the model.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_resp_tag", resp_tag, 0);
      check("rst_resp_err", resp_err, 0);
      q.delete();
    end else begin
      check("req_ready", req_ready, (q.size() == 0));
      if (resp_valid) begin
        if (q.size() == 0) check("spurious_resp_valid", resp_valid, 0);
        else begin
          e = q[0];
          if (e.known) check("resp_rdata", resp_rdata, e.rdata);
          check("resp_tag", resp_tag, e.tag);
          check("resp_err", resp_err, e.err);
          if (!e.seen) begin
            check("latency", cyc - e.acc, RD_LAT - 1);
            q[0].seen = 1;
          end
          if (resp_ready) void'(q.pop_front());
        end
      end else if (q.size() > 0 && (cyc - q[0].acc) > RD_LAT - 1) begin
        check("late_resp_valid", resp_valid, 1);
      end
      if (req_valid && req_ready) begin
        int unsigned idx;
        logic [63:0] m;
        idx = int'(req_addr[10:3]);
        e.err = (req_addr[2:0] != 0) || ((req_addr >> 3) >= 64'(DEPTH));
        e.rdata = e.err ? 64'd0 : mem[idx];
        e.known = e.err ? 1'b1 : known[idx];
        e.tag = req_tag;
        e.acc = cyc + 1;
        e.seen = 0;
        if (req_we && !e.err) begin
`ifdef DMEM_BYTE_EN_EN
          for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{req_be[b]}};
          if (req_be == 8'hFF) known[idx] = 1;
`else
          m = '1;
          known[idx] = 1;
`endif
          mem[idx] = (mem[idx] & ~m) | (req_wdata & m);
        end
        q.push_back(e);
      end
    end
  end

  // Issue one request and wait for its response; hold delays resp_ready.
  task automatic do_req(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] be, input logic [TAG_W-1:0] tag, input int hold,
                        output logic [63:0] rd, output bit er, output logic [TAG_W-1:0] tg);
    bit ok;
    rd = '0; er = 0; tg = '0;
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_be = be; req_tag = tag; resp_ready = (hold == 0);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = req_ready; end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 0; req_addr = 64'hFFFF_FFFF_FFFF_FFF8; req_wdata = '1; req_tag = '1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = resp_valid; end
    if (!ok) check("resp_timeout", 0, 1);
    rd = resp_rdata; er = resp_err; tg = resp_tag;
    for (int i = 0; i < hold; i++) @(negedge clk);
    if (hold > 0) begin
      @(posedge clk); #1; resp_ready = 1;
    end
    @(posedge clk); #1;
  endtask

  logic [63:0]      rd;
  bit               er;
  logic [TAG_W-1:0] tg;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Load after reset
    do_req(0, 64'h10, 0, 8'hFF, 5'd5, 0, rd, er, tg);
    check("t1_err", er, 0); check("t1_tag", tg, 5);

    // Store then load
    do_req(1, 64'h40, 64'hDEADBEEF_CAFEF00D, 8'hFF, 5'd3, 0, rd, er, tg);
    check("t2_st_err", er, 0); check("t2_st_tag", tg, 3);
    do_req(0, 64'h40, 0, 8'hFF, 5'd7, 0, rd, er, tg);
    check("t2_ld_rdata", rd, 64'hDEADBEEF_CAFEF00D); check("t2_ld_tag", tg, 7);

    // Errors
    do_req(0, 64'h43, 0, 8'hFF, 5'd9, 0, rd, er, tg);
    check("t3_mis_err", er, 1); check("t3_mis_rdata", rd, 0);
    do_req(1, 64'h0, 64'h0, 8'hFF, 5'd1, 0, rd, er, tg);
    do_req(1, 64'h800, 64'h5555_AAAA, 8'hFF, 5'd2, 0, rd, er, tg);
    check("t3_oor_err", er, 1); check("t3_oor_rdata", rd, 0);
    do_req(1, 64'h8000_0000_0000_0000, 64'h77, 8'hFF, 5'd4, 0, rd, er, tg);
    check("t3_hi_err", er, 1);
    do_req(0, 64'h0, 0, 8'hFF, 5'd6, 0, rd, er, tg);
    check("t3_idx0_rdata", rd, 0); check("t3_idx0_err", er, 0);
    do_req(0, 64'h7F8, 0, 8'hFF, 5'd8, 0, rd, er, tg);
    check("t3_last_err", er, 0);

    // Back-pressure
    do_req(0, 64'h40, 0, 8'hFF, 5'd11, 5, rd, er, tg);
    check("t4_rdata", rd, 64'hDEADBEEF_CAFEF00D); check("t4_tag", tg, 11);

    // Reset during WAIT
    @(posedge clk); #1;
    req_valid = 1; req_we = 1; req_addr = 64'h8; req_wdata = 64'h1111; req_tag = 5'd12;
    @(negedge clk);
    check("t5_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (4) @(posedge clk);
    do_req(0, 64'h8, 0, 8'hFF, 5'd13, 0, rd, er, tg);
    check("t5_rdata", rd, 64'h1111); check("t5_tag", tg, 13);

`ifdef DMEM_BYTE_EN_EN
    do_req(1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 5'd14, 0, rd, er, tg);
    do_req(0, 64'h0, 0, 8'h00, 5'd15, 0, rd, er, tg);
    check("t6_be_rdata", rd, 64'h0000_0000_FFFF_FFFF);
    do_req(1, 64'h0, 64'h1234, 8'h00, 5'd16, 0, rd, er, tg);
    check("t6_be0_err", er, 0);
    do_req(0, 64'h0, 0, 8'hFF, 5'd17, 0, rd, er, tg);
    check("t6_be0_rdata", rd, 64'h0000_0000_FFFF_FFFF);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
